// File: rtl/alu_mc_pkg.sv
// Package: alu_mc_pkg
// Shared definitions for the multi-cycle ALU: 4-bit operation codes, the top-level
// FSM state type and the iteration-unit mode type.
package alu_mc_pkg;

   // Operation codes. The original single-cycle codes keep their values; the new
   // operations occupy the next free codes. 4'hB..4'hF are undefined.
   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_OR  = 4'h3;
   localparam logic [3:0] ALU_XOR = 4'h4;
   localparam logic [3:0] ALU_ADC = 4'h5;
   localparam logic [3:0] ALU_SBC = 4'h6;
   localparam logic [3:0] ALU_NOT = 4'h7;
   localparam logic [3:0] ALU_SHL = 4'h8;
   localparam logic [3:0] ALU_SHR = 4'h9;
   localparam logic [3:0] ALU_MUL = 4'hA;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } alu_state_t;

   typedef enum logic [1:0] {
      IterShl,
      IterShr,
      IterMul
   } iter_mode_t;

endpackage

// File: rtl/alu_mc_iter.sv
// Module: alu_mc_iter
// Iteration unit for shifts (one bit per cycle) and unsigned shift-add multiply.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load operands and begin iterating (ignored while busy by the caller)
//   mode        IterShl / IterShr / IterMul
//   a, b        operands (MUL: multiplicand a, multiplier b; shifts: value a)
//   count       number of iterations, must be nonzero
//   done        high during the final iteration cycle; res/carry are valid then
//   res         low N bits of the result after the final iteration
//   carry       shifts: last bit shifted out; MUL: high half of product nonzero
module alu_mc_iter
   import alu_mc_pkg::*;
#(
   parameter int unsigned N = 8,
   localparam int unsigned CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  iter_mode_t    mode,
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   input  logic [CW-1:0] count,
   output logic          done,
   output logic [N-1:0]  res,
   output logic          carry
);

   logic [2*N-1:0] acc_q, acc_d;
   logic [N-1:0]   mcand_q;
   logic [CW-1:0]  cnt_q;
   iter_mode_t     mode_q;
   logic           busy_q;
   logic [N:0]     sum;

   // Shifts keep the value in acc[N-1:0] and the last shifted-out bit in acc[N].
   // MUL keeps the partial product in the upper half and the multiplier in the
   // lower half, consuming one multiplier bit per cycle from the bottom.
   always_comb begin
      sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, (acc_q[0] ? mcand_q : {N{1'b0}})};
      acc_d = acc_q;
      case (mode_q)
         IterShl: acc_d = {{(N-1){1'b0}}, acc_q[N-1], acc_q[N-2:0], 1'b0};
         IterShr: acc_d = {{(N-1){1'b0}}, acc_q[0], 1'b0, acc_q[N-1:1]};
         IterMul: acc_d = {sum, acc_q[N-1:1]};
         default: acc_d = acc_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         mode_q  <= IterShl;
         busy_q  <= 1'b0;
      end else if (start) begin
         acc_q   <= (mode == IterMul) ? {{N{1'b0}}, b} : {{N{1'b0}}, a};
         mcand_q <= a;
         cnt_q   <= count;
         mode_q  <= mode;
         busy_q  <= 1'b1;
      end else if (busy_q) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_q <= 1'b0;
         end
      end
   end

   // The caller latches res/carry on the same edge that commits the last step.
   assign done  = busy_q && (cnt_q == CW'(1));
   assign res   = acc_d[N-1:0];
   assign carry = (mode_q == IterMul) ? |acc_d[2*N-1:N] : acc_d[N];

endmodule

// File: rtl/alu_mc.sv
// Module: alu_mc
// Multi-cycle ALU with valid/ready handshakes on operands and result, full Z/C/N/V
// flags, single-cycle arithmetic/logic ops and iterative SHL/SHR/MUL.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   op, in_a, in_b        operation and operands; shifts use in_b[SHW-1:0]
//   carry_in              carry input for ADC/SBC
//   out_valid / out_ready result handshake
//   out, flag_*           registered result and flags, updated on entry to DONE
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   op,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic         carry_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out,
   output logic         flag_zero,
   output logic         flag_carry,
   output logic         flag_neg,
   output logic         flag_ovf
);

   localparam int unsigned SHW = $clog2(N);
   localparam int unsigned CW  = $clog2(N + 1);

   alu_state_t    state_q, state_d;
   logic [N-1:0]  out_q, res_d;
   logic          zero_q, carry_q, neg_q, ovf_q;
   logic          carry_d, ovf_d;
   logic          start, load_c, load_i;

   logic [N:0]    add_sum, sub_diff;
   logic [N-1:0]  c_res;
   logic          c_carry, c_ovf;
   logic [SHW-1:0] amt;
   logic          is_iter;

   iter_mode_t    it_mode;
   logic [CW-1:0] it_count;
   logic          it_done, it_carry;
   logic [N-1:0]  it_res;

   assign amt     = in_b[SHW-1:0];
   // Zero-amount shifts complete in one cycle and never enter BUSY.
   assign is_iter = (op == ALU_MUL) || (((op == ALU_SHL) || (op == ALU_SHR)) && (amt != '0));

   // Single-cycle datapath
   always_comb begin
      add_sum  = {1'b0, in_a} + {1'b0, in_b} + {{N{1'b0}}, (op == ALU_ADC) & carry_in};
      sub_diff = {1'b0, in_a} - {1'b0, in_b} - {{N{1'b0}}, (op == ALU_SBC) & ~carry_in};
      c_res    = '0;
      c_carry  = 1'b0;
      c_ovf    = 1'b0;
      case (op)
         ALU_ADD, ALU_ADC: begin
            c_res   = add_sum[N-1:0];
            c_carry = add_sum[N];
            c_ovf   = (in_a[N-1] == in_b[N-1]) && (add_sum[N-1] != in_a[N-1]);
         end
         ALU_SUB, ALU_SBC: begin
            c_res   = sub_diff[N-1:0];
            c_carry = sub_diff[N];  // borrow
            c_ovf   = (in_a[N-1] != in_b[N-1]) && (sub_diff[N-1] != in_a[N-1]);
         end
         ALU_AND: c_res = in_a & in_b;
         ALU_OR:  c_res = in_a | in_b;
         ALU_XOR: c_res = in_a ^ in_b;
         ALU_NOT: c_res = ~in_a;
         ALU_SHL, ALU_SHR: c_res = in_a;
         default: c_res = '0;
      endcase
   end

   assign it_mode  = (op == ALU_MUL) ? IterMul : ((op == ALU_SHL) ? IterShl : IterShr);
   assign it_count = (op == ALU_MUL) ? CW'(N) : CW'(amt);

   alu_mc_iter #(
      .N (N)
   ) u_iter (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .mode  (it_mode),
      .a     (in_a),
      .b     (in_b),
      .count (it_count),
      .done  (it_done),
      .res   (it_res),
      .carry (it_carry)
   );

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      load_c  = 1'b0;
      load_i  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               if (is_iter) begin
                  start   = 1'b1;
                  state_d = StBusy;
               end else begin
                  load_c  = 1'b1;
                  state_d = StDone;
               end
            end
         end
         StBusy: begin
            if (it_done) begin
               load_i  = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign res_d   = load_i ? it_res : c_res;
   assign carry_d = load_i ? it_carry : c_carry;
   assign ovf_d   = load_i ? 1'b0 : c_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         out_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_c || load_i) begin
            out_q   <= res_d;
            zero_q  <= (res_d == '0);
            carry_q <= carry_d;
            neg_q   <= res_d[N-1];
            ovf_q   <= ovf_d;
         end
      end
   end

   assign in_ready   = (state_q == StIdle);
   assign out_valid  = (state_q == StDone);
   assign out        = out_q;
   assign flag_zero  = zero_q;
   assign flag_carry = carry_q;
   assign flag_neg   = neg_q;
   assign flag_ovf   = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Testbench: tb_alu_mc
// Directed vectors against an 8-bit and a 16-bit alu_mc instance.
module tb_alu_mc;
   import alu_mc_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 8-bit instance signals
   logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, cin8 = 1'b0;
   logic [3:0] op8 = 4'h0;
   logic [7:0] a8 = '0, b8 = '0, out8;
   logic       z8, c8, n8, v8;

   // 16-bit instance signals
   logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0;
   logic [3:0]  op16 = 4'h0;
   logic [15:0] a16 = '0, b16 = '0, out16;
   logic        z16, c16, n16, v16;

   int checks = 0;
   int errors = 0;

   alu_mc #(.N(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
      .in_a(a8), .in_b(b8), .carry_in(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
      .out(out8), .flag_zero(z8), .flag_carry(c8), .flag_neg(n8), .flag_ovf(v8)
   );

   alu_mc #(.N(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
      .in_a(a16), .in_b(b16), .carry_in(1'b0), .out_valid(out_valid16),
      .out_ready(out_ready16), .out(out16), .flag_zero(z16), .flag_carry(c16),
      .flag_neg(n16), .flag_ovf(v16)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one op, measure latency to out_valid (bounded), check result and {Z,C,N,V}.
   task automatic run8(input string tag, input logic [3:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input logic [7:0] eo,
                       input logic [3:0] ef, input int elat);
      int lat;
      @(negedge clk);
      chk({tag, ".rdy"}, 32'(in_ready8), 32'd1);
      in_valid8 = 1'b1; op8 = o; a8 = a; b8 = b; cin8 = ci;
      @(negedge clk);
      in_valid8 = 1'b0;
      lat = 1;
      while (!out_valid8 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, ".lat"}, 32'(lat), 32'(elat));
      chk({tag, ".out"}, 32'(out8), 32'(eo));
      chk({tag, ".flg"}, 32'({z8, c8, n8, v8}), 32'(ef));
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
   endtask

   task automatic mul16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eo, input logic [3:0] ef);
      int lat;
      @(negedge clk);
      in_valid16 = 1'b1; op16 = ALU_MUL; a16 = a; b16 = b;
      @(negedge clk);
      in_valid16 = 1'b0;
      lat = 1;
      while (!out_valid16 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, ".lat"}, 32'(lat), 32'd17);
      chk({tag, ".out"}, 32'(out16), 32'(eo));
      chk({tag, ".flg"}, 32'({z16, c16, n16, v16}), 32'(ef));
      out_ready16 = 1'b1;
      @(negedge clk);
      out_ready16 = 1'b0;
   endtask

   initial begin
      int seen;
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst.rdy", 32'(in_ready8), 32'd1);
      chk("rst.vld", 32'(out_valid8), 32'd0);
      chk("rst.out", 32'(out8), 32'd0);
      chk("rst.flg", 32'({z8, c8, n8, v8}), 32'd0);
      rst_n = 1'b1;

      // Single-cycle ops; flags are {Z,C,N,V}
      run8("add",  ALU_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1100, 1);
      run8("sub",  ALU_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0001, 1);
      run8("sbc",  ALU_SBC, 8'h05, 8'h05, 1'b0, 8'hFF, 4'b0110, 1);
      run8("adc",  ALU_ADC, 8'h7F, 8'h00, 1'b1, 8'h80, 4'b0011, 1);
      run8("and",  ALU_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000, 1);
      run8("xor",  ALU_XOR, 8'h55, 8'h55, 1'b0, 8'h00, 4'b1000, 1);
      run8("not",  ALU_NOT, 8'hA5, 8'h00, 1'b0, 8'h5A, 4'b0000, 1);
      run8("or",   ALU_OR,  8'h81, 8'h02, 1'b1, 8'h83, 4'b0010, 1);
      run8("undef", 4'hF,   8'hFF, 8'hFF, 1'b1, 8'h00, 4'b1000, 1);

      // Iterative ops
      run8("mul1", ALU_MUL, 8'h10, 8'h10, 1'b0, 8'h00, 4'b1100, 9);
      run8("mul2", ALU_MUL, 8'h0F, 8'h03, 1'b0, 8'h2D, 4'b0000, 9);
      run8("shl1", ALU_SHL, 8'h81, 8'h01, 1'b0, 8'h02, 4'b0100, 2);
      run8("shr0", ALU_SHR, 8'h81, 8'h00, 1'b0, 8'h81, 4'b0010, 1);
      run8("shr3", ALU_SHR, 8'h84, 8'h03, 1'b0, 8'h10, 4'b0100, 4);
      run8("shl7", ALU_SHL, 8'h01, 8'h07, 1'b0, 8'h80, 4'b0010, 8);

      // Backpressure: result held, new requests ignored
      @(negedge clk);
      in_valid8 = 1'b1; op8 = ALU_ADD; a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0;
      @(negedge clk);
      op8 = ALU_SUB; a8 = 8'h10; b8 = 8'h01;
      for (int i = 0; i < 5; i++) begin
         chk("bp.vld", 32'(out_valid8), 32'd1);
         chk("bp.rdy", 32'(in_ready8), 32'd0);
         chk("bp.out", 32'(out8), 32'h07);
         chk("bp.flg", 32'({z8, c8, n8, v8}), 32'd0);
         @(negedge clk);
      end
      in_valid8 = 1'b0;
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
      chk("bp.idle", 32'(in_ready8), 32'd1);
      chk("bp.ivld", 32'(out_valid8), 32'd0);
      chk("bp.hold", 32'(out8), 32'h07);

      // Reset in the middle of a multiply
      @(negedge clk);
      in_valid8 = 1'b1; op8 = ALU_MUL; a8 = 8'h0F; b8 = 8'h03;
      @(negedge clk);
      in_valid8 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mr.out", 32'(out8), 32'd0);
      chk("mr.flg", 32'({z8, c8, n8, v8}), 32'd0);
      chk("mr.rdy", 32'(in_ready8), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid8) seen++;
      end
      chk("mr.novld", 32'(seen), 32'd0);
      chk("mr.rdy2", 32'(in_ready8), 32'd1);
      chk("mr.out2", 32'(out8), 32'd0);

      // 16-bit multiply sweep
      mul16("m16a", 16'h00FF, 16'h00FF, 16'hFE01, 4'b0010);
      mul16("m16b", 16'h0100, 16'h0100, 16'h0000, 4'b1100);
      mul16("m16c", 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0100);
      mul16("m16d", 16'h1234, 16'h0003, 16'h369C, 4'b0000);
      mul16("m16e", 16'h8000, 16'h0002, 16'h0000, 4'b1100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
